load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the core data-memory bus; memctl is the responder. Accepts one
//  load/store at a time from the execute stage and drives the mem_* request until
//  mem_valid. Returns sign/zero-extended load data, or an error, as a one-cycle result.
//  Sits between the pipeline and memctl; memctl data is right-justified (byte in [7:0]).
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles without mem_valid before abort (LSU_TIMEOUT_EN only)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-low reset
//  req_valid        in   1   pipeline request present
//  req_ready        out  1   LSU can accept; high only in IDLE
//  req_write        in   1   1=store, 0=load
//  req_funct3       in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data, right-justified
//  resp_valid       out  1   one-cycle result strobe
//  resp_rdata       out  32  extended load data; 0 for stores and errors
//  resp_err         out  1   misaligned, illegal funct3 or timeout; valid with resp_valid
//  mem_addr         out  32  bus address
//  mem_read_valid   out  1   read request, held until mem_valid
//  mem_write_valid  out  1   write request, held until mem_valid
//  mem_write_data   out  32  store data masked to width
//  mem_width        out  2   0=byte 1=half 2=word
//  mem_read_data    in   32  read data, right-justified, sampled when mem_valid
//  mem_valid        in   1   responder completion
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 once rst is released; every other output 0; timeout counter 0.
//  FSM: IDLE -> BUSY on an accepted legal request. IDLE -> RESP on an accepted illegal
//   request. BUSY -> RESP when mem_valid is high. RESP -> IDLE always.
//  Accept = req_valid && req_ready. Request fields are registered at acceptance.
//  Illegal: H at addr[0]!=0; W at addr[1:0]!=0; funct3 011/110/111; a store with funct3[2]=1.
//   An illegal request issues no bus cycle. resp_err=1, resp_rdata=0.
//  BUSY: mem_*_valid, mem_addr, mem_width and mem_write_data are registered and stable
//   for the whole of BUSY. They drop to 0 on the edge that leaves BUSY.
//  mem_valid in IDLE/RESP is ignored. mem_valid in the first BUSY cycle completes the request.
//  Latency: accept at edge N; bus valid high N+1..M, where M is the first BUSY cycle with
//   mem_valid; resp_valid high for exactly cycle M+1. Minimum accept-to-resp is 2 cycles.
//  Store data: B {24'b0,wdata[7:0]}; H {16'b0,wdata[15:0]}; W wdata.
//  Load extend: B sext rd[7:0]; BU zext rd[7:0]; H sext rd[15:0]; HU zext rd[15:0]; W rd.
//  Load data is captured at the mem_valid edge and held only while resp_valid is high.
//  No response backpressure: the pipeline must consume resp_valid in that cycle.
//  Reset asserted mid-transaction: bus valids drop asynchronously. The transaction is
//   lost and no resp_valid is produced.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   - Counter clears on entry to BUSY and increments each BUSY cycle without mem_valid.
//   - On reaching TIMEOUT_CYCLES: bus valids drop, FSM goes to RESP with resp_err=1, resp_rdata=0.
//   - mem_valid in the same cycle as the timeout wins, giving a normal completion.
//  LSU_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for mem_valid.
// TESTING
//  LB 0x1003, mem_read_data=0x00000080 after 2 wait cycles -> resp_rdata=0xFFFFFF80, err=0
//  LBU same -> 0x00000080; LHU 0x1002 rd=0x1234F00D -> 0x0000F00D; LH -> 0xFFFFF00D
//  SW 0x1004 data 0xDEADBEEF, mem_valid after 3 cycles -> write_valid,width=2,data stable
//   3 cycles; resp_valid 1 cycle later
//  SB 0x1005 data 0xAABBCCDD -> mem_write_data=0x000000DD, mem_width=0
//  LW 0x1002 -> no mem_*_valid; resp_valid,err=1 at accept+1; req_ready back next cycle
//  rst low during BUSY -> bus valids 0 immediately; no resp_valid after release;
//   a new request is accepted normally
//  LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_valid -> err=1 after 8 BUSY cycles;
//   mem_valid at cycle 8 -> normal resp

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: issues one data-memory bus request at a time and returns a one-cycle result.
// Optional LSU_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES busy cycles without mem_valid.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_read_valid_q, mem_read_valid_d;
    logic        mem_write_valid_q, mem_write_valid_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [1:0]  mem_width_q, mem_width_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        accept_c;
    logic        req_illegal_c;
    logic        timeout_c;
    logic [31:0] wdata_masked_c;
    logic [31:0] load_ext_c;

    assign accept_c = req_valid && req_ready_q;

    // Unsupported encodings, stores with the unsigned bit, and misaligned halves/words
    always_comb begin
        req_illegal_c = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b100: req_illegal_c = req_write && req_funct3[2];
            3'b001, 3'b101: req_illegal_c = req_addr[0] || (req_write && req_funct3[2]);
            3'b010:         req_illegal_c = (req_addr[1:0] != 2'b00);
            default:        req_illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        unique case (req_funct3[1:0])
            2'b00:   wdata_masked_c = {24'b0, req_wdata[7:0]};
            2'b01:   wdata_masked_c = {16'b0, req_wdata[15:0]};
            default: wdata_masked_c = req_wdata;
        endcase
    end

    always_comb begin
        unique case (funct3_q)
            3'b000:  load_ext_c = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b100:  load_ext_c = {24'b0, mem_read_data[7:0]};
            3'b001:  load_ext_c = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b101:  load_ext_c = {16'b0, mem_read_data[15:0]};
            default: load_ext_c = mem_read_data;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts busy cycles that ended without mem_valid; timeout on the last allowed one
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && accept_c) begin
            cnt_d = '0;
        end else if (state_q == BUSY && !mem_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        req_ready_d       = 1'b0;
        resp_valid_d      = 1'b0;
        resp_err_d        = 1'b0;
        resp_rdata_d      = 32'b0;
        mem_addr_d        = mem_addr_q;
        mem_read_valid_d  = mem_read_valid_q;
        mem_write_valid_d = mem_write_valid_q;
        mem_write_data_d  = mem_write_data_q;
        mem_width_d       = mem_width_q;
        funct3_d          = funct3_q;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    req_ready_d = 1'b0;
                    if (req_illegal_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d           = BUSY;
                        funct3_d          = req_funct3;
                        mem_addr_d        = req_addr;
                        mem_read_valid_d  = !req_write;
                        mem_write_valid_d = req_write;
                        mem_write_data_d  = req_write ? wdata_masked_c : 32'b0;
                        mem_width_d       = req_funct3[1:0];
                    end
                end
            end
            BUSY: begin
                if (mem_valid || timeout_c) begin
                    state_d           = RESP;
                    resp_valid_d      = 1'b1;
                    resp_err_d        = !mem_valid;
                    resp_rdata_d      = (mem_valid && mem_read_valid_q) ? load_ext_c : 32'b0;
                    mem_addr_d        = 32'b0;
                    mem_read_valid_d  = 1'b0;
                    mem_write_valid_d = 1'b0;
                    mem_write_data_d  = 32'b0;
                    mem_width_d       = 2'b00;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            req_ready_q       <= 1'b1;
            resp_valid_q      <= 1'b0;
            resp_err_q        <= 1'b0;
            resp_rdata_q      <= 32'b0;
            mem_addr_q        <= 32'b0;
            mem_read_valid_q  <= 1'b0;
            mem_write_valid_q <= 1'b0;
            mem_write_data_q  <= 32'b0;
            mem_width_q       <= 2'b00;
            funct3_q          <= 3'b000;
        end else begin
            state_q           <= state_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_err_q        <= resp_err_d;
            resp_rdata_q      <= resp_rdata_d;
            mem_addr_q        <= mem_addr_d;
            mem_read_valid_q  <= mem_read_valid_d;
            mem_write_valid_q <= mem_write_valid_d;
            mem_write_data_q  <= mem_write_data_d;
            mem_width_q       <= mem_width_d;
            funct3_q          <= funct3_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_read_valid  = mem_read_valid_q;
    assign mem_write_valid = mem_write_valid_q;
    assign mem_write_data  = mem_write_data_q;
    assign mem_width       = mem_width_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences,
// and random transactions checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned TB_TO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_width;
    logic [31:0] mem_read_data;
    logic        mem_valid;

`ifdef LSU_TIMEOUT_EN
    load_store_unit #(.TIMEOUT_CYCLES(TB_TO)) dut (
`else
    load_store_unit dut (
`endif
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_read_valid(mem_read_valid),
        .mem_write_valid(mem_write_valid), .mem_write_data(mem_write_data),
        .mem_width(mem_width), .mem_read_data(mem_read_data), .mem_valid(mem_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        string      name;
        bit         wr;
        bit [2:0]   f3;
        bit [31:0]  addr;
        bit [31:0]  wd;
        bit [31:0]  rd;
        int         wt;
        bit         err;
        bit [31:0]  rdata;
        bit [31:0]  wdm;
        bit [1:0]   width;
    } vec_t;

    function automatic vec_t mk(input string name, input bit wr, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wd, input bit [31:0] rd,
                                input int wt, input bit err, input bit [31:0] rdata,
                                input bit [31:0] wdm, input bit [1:0] width);
        vec_t v;
        v.name = name; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
        v.wt = wt; v.err = err; v.rdata = rdata; v.wdm = wdm; v.width = width;
        return v;
    endfunction

    // Reference: access size in bytes, alignment by modulo, extension by arithmetic
    function automatic void model(input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wd, input bit [31:0] rd,
                                  output bit err, output bit [31:0] rdata,
                                  output bit [31:0] wdm, output bit [1:0] width);
        longint size;
        longint m;
        longint v;
        size  = longint'(1) << f3[1:0];
        width = f3[1:0];
        err   = (f3[1:0] == 2'd3) || (f3 == 3'd6) || (wr && f3 >= 3'd4) ||
                (longint'(addr) % size != 0);
        rdata = 32'b0;
        wdm   = 32'b0;
        if (!err) begin
            m   = longint'(1) << (8 * size);
            wdm = 32'(longint'(wd) % m);
            if (!wr) begin
                v = longint'(rd) % m;
                if (f3 < 3'd4 && size < 4 && v >= m / 2) v = v - m;
                rdata = 32'(v);
            end
        end
    endfunction

    task automatic do_txn(input vec_t v);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({v.name, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wd; mem_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (v.err) begin
            chk({v.name, " err bus"}, {62'b0, mem_read_valid, mem_write_valid}, 64'd0);
            chk({v.name, " err resp"}, {31'b0, resp_valid, resp_err, resp_rdata}, {31'b0, 1'b1, 1'b1, 32'b0});
        end else begin
            for (int k = 0; k <= v.wt; k++) begin
                chk({v.name, " bus"}, {27'b0, resp_valid, !v.wr, v.wr, v.width, v.addr} ^
                                      {27'b0, 1'b0, !v.wr, v.wr, v.width, v.addr} ^
                                      {27'b0, resp_valid, mem_read_valid, mem_write_valid, mem_width, mem_addr},
                    {27'b0, 1'b0, !v.wr, v.wr, v.width, v.addr});
                if (v.wr) chk({v.name, " wdata"}, 64'(mem_write_data), 64'(v.wdm));
                mem_valid     = (k == v.wt);
                mem_read_data = (k == v.wt) ? v.rd : 32'($urandom);
                @(posedge clk); #1;
            end
            mem_valid = 1'b0;
            chk({v.name, " resp"}, {31'b0, resp_valid, resp_err, resp_rdata}, {31'b0, 1'b1, 1'b0, v.rdata});
            chk({v.name, " bus drop"}, {62'b0, mem_read_valid, mem_write_valid}, 64'd0);
        end
        @(posedge clk); #1;
        chk({v.name, " after"}, {62'b0, resp_valid, req_ready}, 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        vec_t v;
        bit e_err;
        bit [31:0] e_rd, e_wdm;
        bit [1:0] e_w;
        int busy_n;

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0; mem_read_data = 32'b0; mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {resp_valid, resp_err, mem_read_valid, mem_write_valid, mem_width,
                              26'b0, resp_rdata | mem_addr | mem_write_data}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset ready", 64'(req_ready), 64'd1);

        // mem_valid while idle must be ignored
        mem_valid = 1'b1; mem_read_data = 32'h5555_5555;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("idle mem_valid", {62'b0, resp_valid, req_ready}, 64'd1);

        vecs.push_back(mk("LB",   0, 3'b000, 32'h1003, 32'h0, 32'h0000_0080, 2, 0, 32'hFFFF_FF80, 32'h0, 2'd0));
        vecs.push_back(mk("LBU",  0, 3'b100, 32'h1003, 32'h0, 32'h0000_0080, 2, 0, 32'h0000_0080, 32'h0, 2'd0));
        vecs.push_back(mk("LHU",  0, 3'b101, 32'h1002, 32'h0, 32'h1234_F00D, 1, 0, 32'h0000_F00D, 32'h0, 2'd1));
        vecs.push_back(mk("LH",   0, 3'b001, 32'h1002, 32'h0, 32'h1234_F00D, 0, 0, 32'hFFFF_F00D, 32'h0, 2'd1));
        vecs.push_back(mk("SW",   1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 32'h0, 2, 0, 32'h0, 32'hDEAD_BEEF, 2'd2));
        vecs.push_back(mk("SB",   1, 3'b000, 32'h1005, 32'hAABB_CCDD, 32'h0, 1, 0, 32'h0, 32'h0000_00DD, 2'd0));
        vecs.push_back(mk("SH",   1, 3'b001, 32'h1002, 32'h1234_5678, 32'h0, 0, 0, 32'h0, 32'h0000_5678, 2'd1));
        vecs.push_back(mk("LW",   0, 3'b010, 32'h1000, 32'h0, 32'h89AB_CDEF, 0, 0, 32'h89AB_CDEF, 32'h0, 2'd2));
        vecs.push_back(mk("LBpos",0, 3'b000, 32'h1001, 32'h0, 32'hFFFF_FF7F, 1, 0, 32'h0000_007F, 32'h0, 2'd0));
        vecs.push_back(mk("LHneg",0, 3'b001, 32'h1000, 32'h0, 32'h0000_8000, 3, 0, 32'hFFFF_8000, 32'h0, 2'd1));
        vecs.push_back(mk("LWmis",0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 2'd2));
        vecs.push_back(mk("SHmis",1, 3'b001, 32'h1001, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 2'd1));
        vecs.push_back(mk("f3_011",0,3'b011, 32'h1000, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 2'd3));
        vecs.push_back(mk("SBU",  1, 3'b100, 32'h1000, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 2'd0));
        vecs.push_back(mk("f3_110",0,3'b110, 32'h1000, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 2'd2));
        foreach (vecs[i]) do_txn(vecs[i]);

        // Reset asserted during BUSY: bus valids drop immediately, no response afterwards
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst busy valid", 64'(mem_read_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst async drop", {62'b0, mem_read_valid, mem_write_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1;
            @(posedge clk); #1;
            chk("rst no resp", 64'(resp_valid), 64'd0);
        end
        mem_valid = 1'b0;
        do_txn(vecs[0]);

`ifdef LSU_TIMEOUT_EN
        // No mem_valid: abort after exactly TB_TO busy cycles
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy_n = 0;
        while (mem_read_valid && busy_n < 50) begin
            busy_n++;
            @(posedge clk); #1;
        end
        chk("timeout cycles", 64'(busy_n), 64'(TB_TO));
        chk("timeout resp", {31'b0, resp_valid, resp_err, resp_rdata}, {31'b0, 1'b1, 1'b1, 32'b0});
        @(posedge clk); #1;
        do_txn(mk("TOwin", 0, 3'b010, 32'h3004, 32'h0, 32'hCAFE_F00D, int'(TB_TO) - 1, 0,
                  32'hCAFE_F00D, 32'h0, 2'd2));
`else
        busy_n = 0;
`endif

        for (int n = 0; n < 200; n++) begin
            v.name = "rand";
            v.wr   = 1'($urandom);
            v.f3   = 3'($urandom);
            v.addr = 32'h4000_0000 | 32'($urandom_range(0, 255));
            v.wd   = $urandom;
            v.rd   = $urandom;
            v.wt   = $urandom_range(0, 4);
            model(v.wr, v.f3, v.addr, v.wd, v.rd, e_err, e_rd, e_wdm, e_w);
            v.err = e_err; v.rdata = e_rd; v.wdm = e_wdm; v.width = e_w;
            do_txn(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
